// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back port.
// Contents: register/index widths, the always-zero register index,
// the buffered write-entry type and the write-buffer fill-state encoding.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Write-buffer occupancy class, exported for debug visibility.
    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_PARTIAL = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_t;

endpackage

// File: rtl/regfile_wb_port_fifo.sv
// wb_fifo: DEPTH-entry synchronous FIFO of write entries.
// Ports:
//   clk, rst_n          clock, async active-low reset (empties the FIFO)
//   push, din           enqueue din at the rising edge (caller guarantees !full or pop)
//   pop                 dequeue the head at the rising edge (caller guarantees !empty)
//   full, empty, count  occupancy (count is 0..DEPTH)
//   head                oldest entry (slot 0)
//   entries, valid      every slot and its valid flag; slot 0 is oldest,
//                       slot count-1 is youngest
//   fill_state          EMPTY / PARTIAL / FULL classification of count
// Storage is a shift register: a pop moves every slot down by one, so the
// head is always slot 0 and age increases with decreasing index.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wr_entry_t                    din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wr_entry_t                    head,
    output wr_entry_t [DEPTH-1:0]        entries,
    output logic [DEPTH-1:0]             valid,
    output fill_state_t                  fill_state
);

    localparam int CW = $clog2(DEPTH + 1);

    wr_entry_t [DEPTH-1:0] slots;
    logic [CW-1:0]         wr_idx;

    // With a simultaneous pop the new entry lands one slot lower because
    // everything shifts down on the same edge.
    assign wr_idx = count - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            slots <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && i < DEPTH - 1) begin
                    slots[i] <= slots[i+1];
                end
                if (push && CW'(i) == wr_idx) begin
                    slots[i] <= din;
                end
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = (CW'(i) < count);
        end
    end

    assign entries = slots;
    assign head    = slots[0];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_comb begin
        fill_state = FILL_PARTIAL;
        if (empty) begin
            fill_state = FILL_EMPTY;
        end else if (full) begin
            fill_state = FILL_FULL;
        end
    end

endmodule

// File: rtl/regfile_wb_port.sv
// regfile_wb_port: register-file write-back port with a posted-write buffer.
// Ports:
//   clk, rst_n              clock, async active-low reset (clears array and buffer)
//   wr_valid/wr_ready       write request handshake; wr_addr/wr_data payload
//   wb_stall                high blocks the buffer-to-array commit this cycle
//   rd_addr_a/b, rd_data_a/b  combinational read ports with buffer bypass
//   busy                    write buffer non-empty
//   fill_state              debug view of buffer occupancy class
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready does not depend on wr_valid; it is high while the buffer has
// room or while a commit frees the head slot in the same cycle, so it is
// combinational from wb_stall. Transfers to register 0 complete but are
// dropped instead of being buffered.
module regfile_wb_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wb_stall,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    busy,
    output regfile_pkg::fill_state_t fill_state
);

    import regfile_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]     regs [NREGS];
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    wr_entry_t             fifo_head;
    wr_entry_t [DEPTH-1:0] fifo_entries;
    logic [DEPTH-1:0]      fifo_valid;
    wr_entry_t             new_entry;
    logic                  accept;
    logic                  push;
    logic                  commit;

    assign wr_ready  = ~fifo_full | ~wb_stall;
    assign accept    = wr_valid & wr_ready;
    assign push      = accept & (wr_addr != ZERO_REG);
    assign commit    = ~fifo_empty & ~wb_stall;
    assign busy      = (fifo_count != '0);
    assign new_entry = '{addr: wr_addr, data: wr_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .din        (new_entry),
        .pop        (commit),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head       (fifo_head),
        .entries    (fifo_entries),
        .valid      (fifo_valid),
        .fill_state (fill_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[fifo_head.addr] <= fifo_head.data;
        end
    end

    // Array value overridden by buffered writes; slots are scanned oldest
    // to youngest so the youngest match is the one that sticks.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = regs[addr];
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && fifo_entries[i].addr == addr) begin
                v = fifo_entries[i].data;
            end
        end
        if (addr == ZERO_REG) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd_data_a = read_port(rd_addr_a);
    end

    always_comb begin
        rd_data_b = read_port(rd_addr_b);
    end

endmodule

// File: tb/tb_regfile_wb_port.sv
module tb_regfile_wb_port;

  import regfile_pkg::*;

  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wb_stall = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy;
  fill_state_t fill_state;

  regfile_wb_port #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wb_stall   (wb_stall),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .busy       (busy),
    .fill_state (fill_state)
  );

  // ---------------- reference model ----------------
  // exp_q holds pending writes {addr, data}, oldest at the front.
  logic [36:0] exp_q[$];
  logic [31:0] exp_regs[32];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    if (a == 5'd0) return 32'd0;
    r = exp_regs[a];
    foreach (exp_q[i]) begin
      if (exp_q[i][36:32] == a) r = exp_q[i][31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_fill();
    if (exp_q.size() == 0) return 32'(FILL_EMPTY);
    if (exp_q.size() == DEPTH) return 32'(FILL_FULL);
    return 32'(FILL_PARTIAL);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle, checks the combinational outputs mid-cycle, then
  // advances the model across the rising edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic s, input logic [4:0] ra, input logic [4:0] rb);
    logic exp_ready;
    logic [36:0] e;
    @(negedge clk);
    wr_valid = v; wr_addr = a; wr_data = d; wb_stall = s;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
    exp_ready = (exp_q.size() < DEPTH) || !s;
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    check("fill_state", 32'(fill_state), model_fill());
    check("rd_data_a", rd_data_a, model_read(ra));
    check("rd_data_b", rd_data_b, model_read(rb));
    @(posedge clk);
    if (exp_q.size() != 0 && !s) begin
      e = exp_q.pop_front();
      exp_regs[e[36:32]] = e[31:0];
    end
    if (v && exp_ready && a != 5'd0) exp_q.push_back({a, d});
  endtask

  task automatic idle(input logic s, input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 5'd0, 32'd0, s, ra, rb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(wr_ready), 32'd1);
    check("reset_rd_a", rd_data_a, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // basic write
    step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd3, 5'd0);
    idle(1'b0, 5'd3, 5'd3);
    idle(1'b0, 5'd3, 5'd0);
    #1 check("r3_const", rd_data_a, 32'hDEADBEEF);

    // register 0 writes are accepted and dropped
    step(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
    idle(1'b1, 5'd3, 5'd0);

    // fill and stall, youngest wins, release accepts in the same cycle
    step(1'b1, 5'd5, 32'd1, 1'b1, 5'd5, 5'd6);
    step(1'b1, 5'd5, 32'd2, 1'b1, 5'd5, 5'd6);
    step(1'b1, 5'd6, 32'd3, 1'b1, 5'd5, 5'd6);
    step(1'b1, 5'd6, 32'd3, 1'b0, 5'd5, 5'd6);
    idle(1'b0, 5'd5, 5'd6);
    idle(1'b0, 5'd5, 5'd6);
    idle(1'b0, 5'd5, 5'd6);
    #1;
    check("r5_final", rd_data_a, 32'd2);
    check("r6_final", rd_data_b, 32'd3);

    // full with simultaneous commit: stays full, ready drops once stalled
    step(1'b1, 5'd7, 32'hA1, 1'b1, 5'd7, 5'd8);
    step(1'b1, 5'd8, 32'hA2, 1'b1, 5'd7, 5'd8);
    step(1'b1, 5'd7, 32'hA3, 1'b0, 5'd7, 5'd8);
    step(1'b1, 5'd9, 32'hA4, 1'b1, 5'd7, 5'd9);
    for (int i = 0; i < 4; i++) idle(1'b0, 5'd7, 5'd8);

    // reset mid-operation
    step(1'b1, 5'd10, 32'h55, 1'b1, 5'd10, 5'd11);
    step(1'b1, 5'd11, 32'h66, 1'b1, 5'd10, 5'd11);
    @(negedge clk);
    wb_stall = 1'b1; wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(wr_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 5'd10, 5'd11);
    #1;
    check("midrst_r10", rd_data_a, 32'd0);
    check("midrst_r3", model_read(5'd3), 32'd0);

    // randomized traffic, addresses clustered for frequent bypass hits
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 4; i++) idle(1'b0, 5'd1, 5'd2);
    for (int r = 0; r < 32; r++) idle(1'b0, 5'(r), 5'(31 - r));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_port.md
# regfile_wb_port

Register-file write-back port with a small posted-write buffer. It is the consuming end of the 5-bit destination-register select produced in the write-back path: it accepts (destination, data) write requests over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Queued entries commit into the 32×32 register array one per cycle unless `wb_stall` is asserted. Two combinational read ports return the array value, overridden by the youngest pending buffered write to the same register.

## Interface
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width; 2**ADDR_W registers
- `DEPTH`, 2, write-buffer entries (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_valid`  in  1  write request present
- `wr_ready`  out  1  write request can be accepted this cycle
- `wr_addr`  in  ADDR_W  destination register
- `wr_data`  in  DATA_W  write data
- `wb_stall`  in  1  high: no commit from buffer to array this cycle
- `rd_addr_a`, `rd_addr_b`  in  ADDR_W  read indices
- `rd_data_a`, `rd_data_b`  out  DATA_W  read data (combinational)
- `busy`  out  1  buffer non-empty (count ≠ 0)

## Operation
- Accept = `wr_valid & wr_ready` at a rising edge.
- Accepted writes to register 0 are consumed and discarded; they are never enqueued and `busy` is unaffected.
- FIFO occupancy `count` ranges 0..DEPTH.
  - States: EMPTY (0), PARTIAL, FULL (DEPTH).
  - Commit = `count≠0 & ~wb_stall`: head entry is written to the array and popped at the edge.
- `wr_ready = (count < DEPTH) | ~wb_stall`.
  - When FULL and a commit occurs in the same cycle, the enqueue is accepted; `count` is unchanged.
  - This path is combinational from `wb_stall` to `wr_ready`.
- Simultaneous accept and commit with `count`=0 cannot occur, since commit requires non-empty. The new entry lands in the FIFO.
- Read: `rd_data_x` = 0 if `rd_addr_x`=0.
  - Otherwise it is the youngest buffered entry with a matching address.
  - If no entry matches, it is the array value.
  - A request in its acceptance cycle is not visible.
- Reset:
  - All array registers are cleared to 0 and the buffer is emptied, so `count`=0.
  - Outputs under reset: `busy`=0, `wr_ready`=1, `rd_data_*`=0.
  - Pending writes at reset assertion are lost, including mid-commit.
- No overflow or underflow is possible by construction. Enqueue only happens with `wr_ready`=1; commit only happens with `count`≠0.

## Timing
- Write accepted at edge N:
  - Readable via bypass from N+ (after edge N).
  - Committed to the array at edge N+1 at the earliest, if it is at the head and `wb_stall`=0 in cycle N+1.
- A commit does not change read data: the bypass value equals the committed value.
- The commit order equals the acceptance order (in-order FIFO).
- Read latency is 0 cycles (combinational mux over the array and DEPTH buffer entries).
- With sustained `wb_stall`=1, the buffer fills after DEPTH accepts, then `wr_ready`=0.

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_W`, `DATA_W`
  - `ZERO_REG` = 0
  - a write-entry struct/typedef {addr, data}
- Sub-module `wb_fifo`: DEPTH-entry synchronous FIFO with push, pop, full, empty, count, and a flat view of all entries plus per-entry valid flags for bypass search.
- Top level holds:
  - the register array
  - the ready logic
  - the two bypass/priority read muxes (youngest wins)

## Test plan
- Reset mid-operation:
  - Stimulus: 2 entries queued with `wb_stall`=1, then assert `rst_n`=0.
  - Required: `busy`=0, `wr_ready`=1; `rd_data_a` for those registers = 0 after release.
- Basic write:
  - Stimulus: write r3=0xDEADBEEF with `wb_stall`=0.
  - Required: `rd_data_a`(r3)=0xDEADBEEF from the next cycle; `busy`=1 for one cycle, then 0.
- Register 0 writes:
  - Stimulus: write r0=0x12345678.
  - Required: accepted (`wr_ready`=1); `busy` stays 0; `rd_data_b`(r0)=0.
- Fill and stall:
  - Stimulus: `wb_stall`=1; write r5=1, r5=2, then attempt r6=3.
  - Required: `wr_ready`=0 on the third request; `rd_data_a`(r5)=2 (youngest wins).
  - Then drop `wb_stall`: r6 is accepted in that same cycle; r5 commits 1 then 2; final r5=2, r6=3.
- Full with simultaneous commit:
  - Stimulus: FULL with `wb_stall`=0 and `wr_valid`=1.
  - Required: accept and commit on the same edge; `count` stays DEPTH; commit order is verified against a scoreboard model.
